// File: rtl/adbg_or1k_stall_pkg.sv
// Shared types and helpers for the OR1K stall/reset sequencer.
package adbg_or1k_stall_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE_STALL,
        RST,
        POST
    } stall_seq_state_t;

    // Width able to hold the largest of the three sequence counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/adbg_or1k_bp_latch.sv
// Per-core sticky breakpoint latch; a set in the same cycle as a clear wins.
module adbg_or1k_bp_latch #(
    parameter int unsigned NCORES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCORES-1:0] set_i,
    input  logic [NCORES-1:0] clr_i,
    output logic [NCORES-1:0] latch_o
);

    logic [NCORES-1:0] latch_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latch_q <= '0;
        end else begin
            latch_q <= (latch_q & ~clr_i) | set_i;
        end
    end

    assign latch_o = latch_q;

endmodule

// File: rtl/adbg_or1k_stall_ctrl.sv
// CPU-domain stall merge and ordered reset sequencer for an OR1K cluster:
// stall -> wait quiesce/timeout -> reset -> release -> hold stall.
module adbg_or1k_stall_ctrl
    import adbg_or1k_stall_pkg::*;
#(
    parameter int unsigned NCORES      = 4,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned POST_HOLD   = 2
) (
    input  logic              cpu_clk_i,
    input  logic              rst_i,
    input  logic [NCORES-1:0] host_stall_i,
    input  logic              host_rst_i,
    input  logic [NCORES-1:0] rst_mask_i,
    input  logic [NCORES-1:0] bp_i,
    input  logic [NCORES-1:0] bp_clr_i,
    input  logic              xtrig_en_i,
    input  logic [NCORES-1:0] stall_ack_i,
    output logic [NCORES-1:0] cpu_stall_o,
    output logic [NCORES-1:0] cpu_rst_o,
    output logic [NCORES-1:0] bp_latched_o,
    output logic              seq_busy_o,
    output logic              timeout_o
);

    localparam int CW = cnt_width(int'(RST_CYCLES), int'(ACK_TIMEOUT), int'(POST_HOLD));

    stall_seq_state_t  state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NCORES-1:0] mask_q, mask_d;
    logic [NCORES-1:0] rst_q, rst_d;
    logic              timeout_q, timeout_d;
    logic              host_rst_q;
    logic              armed_q;
    logic              host_rise;
    logic [NCORES-1:0] latch;
    logic              xt;
    logic [NCORES-1:0] base_stall;

    adbg_or1k_bp_latch #(
        .NCORES (NCORES)
    ) u_bp_latch (
        .clk_i   (cpu_clk_i),
        .rst_i   (rst_i),
        .set_i   (bp_i),
        .clr_i   (bp_clr_i),
        .latch_o (latch)
    );

    // armed_q keeps a level already high when rst_i releases from reading as an edge.
    assign host_rise = armed_q & host_rst_i & ~host_rst_q;

    always_ff @(posedge cpu_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            rst_q      <= '0;
            timeout_q  <= 1'b0;
            host_rst_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            rst_q      <= rst_d;
            timeout_q  <= timeout_d;
            host_rst_q <= host_rst_i;
            armed_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (host_rise) begin
                    state_d   = PRE_STALL;
                    mask_d    = rst_mask_i;
                    timeout_d = 1'b0;
                    cnt_d     = CW'(ACK_TIMEOUT);
                end
            end
            PRE_STALL: begin
                cnt_d = cnt_q - 1'b1;
                if ((stall_ack_i & mask_q) == mask_q) begin
                    state_d = RST;
                    cnt_d   = CW'(RST_CYCLES);
                end else if (cnt_q == CW'(1)) begin
                    state_d   = RST;
                    cnt_d     = CW'(RST_CYCLES);
                    timeout_d = 1'b1;
                end
            end
            RST: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = POST;
                    cnt_d   = CW'(POST_HOLD);
                end
            end
            POST: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered reset lines up exactly with the cycles spent in RST.
        rst_d = (state_d == RST) ? mask_d : '0;
    end

    always_comb begin
        seq_busy_o   = (state_q != IDLE);
        xt           = xtrig_en_i & ((|latch) | (|bp_i));
        base_stall   = host_stall_i | bp_i | latch | {NCORES{xt}};
        cpu_stall_o  = base_stall | ({NCORES{seq_busy_o}} & mask_q);
        cpu_rst_o    = rst_q;
        bp_latched_o = latch;
        timeout_o    = timeout_q;
    end

endmodule

// File: tb/tb_adbg_or1k_stall_ctrl.sv
// Bench for adbg_or1k_stall_ctrl: elapsed-time reference model checked every cycle, plus directed literal checks.
module tb_adbg_or1k_stall_ctrl;

    localparam int N           = 4;
    localparam int RST_CYCLES  = 16;
    localparam int ACK_TIMEOUT = 255;
    localparam int POST_HOLD   = 2;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [N-1:0] host_stall, rst_mask, bp, bp_clr, stall_ack;
    logic         host_rst, xtrig;
    logic [N-1:0] cpu_stall, cpu_rst, bp_latched;
    logic         seq_busy, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    adbg_or1k_stall_ctrl #(
        .NCORES      (N),
        .RST_CYCLES  (RST_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .POST_HOLD   (POST_HOLD)
    ) dut (
        .cpu_clk_i    (clk),
        .rst_i        (rst_i),
        .host_stall_i (host_stall),
        .host_rst_i   (host_rst),
        .rst_mask_i   (rst_mask),
        .bp_i         (bp),
        .bp_clr_i     (bp_clr),
        .xtrig_en_i   (xtrig),
        .stall_ack_i  (stall_ack),
        .cpu_stall_o  (cpu_stall),
        .cpu_rst_o    (cpu_rst),
        .bp_latched_o (bp_latched),
        .seq_busy_o   (seq_busy),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    // Model: a sequence is tracked as the elapsed cycle index since it started.
    logic [N-1:0] m_latch, m_mask;
    logic         m_prev, m_armed, m_active, m_tmo;
    int           m_e, m_prelen;

    always @(posedge clk or posedge rst_i) begin
        int e, pl;
        logic act, tmo;
        if (rst_i) begin
            m_latch <= '0; m_mask <= '0; m_prev <= 1'b0; m_armed <= 1'b0;
            m_active <= 1'b0; m_tmo <= 1'b0; m_e <= 0; m_prelen <= 0;
        end else begin
            e = m_e; pl = m_prelen; act = m_active; tmo = m_tmo;
            if (m_active) begin
                if (pl == 0) begin
                    if ((stall_ack & m_mask) == m_mask) pl = e + 1;
                    else if (e + 1 == ACK_TIMEOUT) begin pl = e + 1; tmo = 1'b1; end
                end
                e = e + 1;
                if (pl != 0 && e >= pl + RST_CYCLES + POST_HOLD) act = 1'b0;
            end else if (m_armed && host_rst && !m_prev) begin
                act = 1'b1; e = 0; pl = 0; tmo = 1'b0;
                m_mask <= rst_mask;
            end
            m_e <= e; m_prelen <= pl; m_active <= act; m_tmo <= tmo;
            m_prev  <= host_rst;
            m_armed <= 1'b1;
            m_latch <= (m_latch & ~bp_clr) | bp;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [N-1:0] e_rst, e_stall;
        logic         xt;
        xt      = xtrig & ((|m_latch) | (|bp));
        e_rst   = (m_active && m_prelen != 0 && m_e >= m_prelen && m_e < m_prelen + RST_CYCLES) ? m_mask : '0;
        e_stall = host_stall | bp | m_latch | {N{xt}} | (m_active ? m_mask : '0);
        chk("cyc_stall",   32'(cpu_stall),  32'(e_stall));
        chk("cyc_rst",     32'(cpu_rst),    32'(e_rst));
        chk("cyc_busy",    32'(seq_busy),   32'(m_active));
        chk("cyc_timeout", 32'(timeout),    32'(m_tmo));
        chk("cyc_latched", 32'(bp_latched), 32'(m_latch));
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        rst_i = 1'b1; host_stall = '0; rst_mask = '0; bp = '0; bp_clr = '0;
        stall_ack = '0; host_rst = 1'b0; xtrig = 1'b0;
        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall",   32'(cpu_stall), 0);
        chk("rst_rst",     32'(cpu_rst),   0);
        chk("rst_busy",    32'(seq_busy),  0);
        chk("rst_timeout", 32'(timeout),   0);
        rst_i = 1'b0;
        tick();

        // Breakpoint stall without and with cross-trigger
        bp = 4'b0010;
        @(negedge clk); chk("bp_same_cycle", 32'(cpu_stall), 32'h2);
        tick(); bp = '0;
        @(negedge clk); chk("bp_latched", 32'(bp_latched), 32'h2); chk("bp_held", 32'(cpu_stall), 32'h2);
        tick(); bp_clr = 4'b0010;
        @(negedge clk); chk("bp_clr_cycle", 32'(cpu_stall), 32'h2);
        tick(); bp_clr = '0;
        @(negedge clk); chk("bp_cleared", 32'(cpu_stall), 32'h0);
        tick(); xtrig = 1'b1; bp = 4'b0010;
        @(negedge clk); chk("xt_same_cycle", 32'(cpu_stall), 32'hF);
        tick(); bp = '0;
        @(negedge clk); chk("xt_held", 32'(cpu_stall), 32'hF);
        tick(); bp_clr = 4'b0010;
        tick(); bp_clr = '0;
        @(negedge clk); chk("xt_cleared", 32'(cpu_stall), 32'h0);
        xtrig = 1'b0;

        // Set wins over clear
        tick(); bp = 4'b0001; bp_clr = 4'b0001;
        tick(); bp = '0; bp_clr = '0;
        @(negedge clk); chk("set_wins", 32'(bp_latched), 32'h1);
        tick(); bp_clr = 4'b0001;
        tick(); bp_clr = '0;
        @(negedge clk); chk("clr_after", 32'(bp_latched), 32'h0);

        // Acked sequence, mask 0101
        tick(); rst_mask = 4'b0101; host_rst = 1'b1;
        tick();
        @(negedge clk); chk("seq_stall_first", 32'(cpu_stall), 32'h5); chk("seq_busy_first", 32'(seq_busy), 1);
        tick(); tick(); stall_ack = 4'b0101;
        n = 0;
        while (cpu_rst == '0 && n < 600) begin @(negedge clk); n++; end
        chk("seq_rst_value", 32'(cpu_rst), 32'h5);
        n = 0;
        while (cpu_rst == 4'b0101 && n < 100) begin n++; @(negedge clk); end
        chk("seq_rst_len", n, RST_CYCLES);
        chk("seq_post_stall", 32'(cpu_stall), 32'h5);
        n = 0;
        while (seq_busy && n < 100) begin n++; @(negedge clk); end
        chk("seq_post_len", n, POST_HOLD);
        chk("seq_no_timeout", 32'(timeout), 0);
        stall_ack = '0; host_rst = 1'b0;

        // Timeout sequence, mask 1111 with core 3 never acking
        tick(); rst_mask = 4'b1111; stall_ack = 4'b0111; host_rst = 1'b1;
        tick();
        @(negedge clk);
        n = 0;
        while (seq_busy && cpu_rst == '0 && n < 400) begin n++; @(negedge clk); end
        chk("to_pre_len", n, ACK_TIMEOUT);
        chk("to_rst_value", 32'(cpu_rst), 32'hF);
        chk("to_flag", 32'(timeout), 1);
        n = 0;
        while (seq_busy && n < 100) begin n++; @(negedge clk); end
        chk("to_sticky", 32'(timeout), 1);

        // Empty mask: same timing, nothing asserted, timeout cleared at start
        tick(); host_rst = 1'b0;
        tick(); host_rst = 1'b1; rst_mask = '0; stall_ack = '0;
        tick();
        @(negedge clk); chk("empty_to_clr", 32'(timeout), 0); chk("empty_stall", 32'(cpu_stall), 0);
        n = 0;
        while (seq_busy && n < 100) begin n++; @(negedge clk); end
        chk("empty_len", n, 1 + RST_CYCLES + POST_HOLD);
        host_rst = 1'b0;

        // Async reset during RST; host_rst level held across release
        tick(); rst_mask = 4'b0011; stall_ack = 4'b0011; host_rst = 1'b1;
        n = 0;
        while (cpu_rst == '0 && n < 600) begin @(negedge clk); n++; end
        chk("ar_rst_before", 32'(cpu_rst), 32'h3);
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b1;
        #1;
        chk("ar_rst_drop",   32'(cpu_rst),   0);
        chk("ar_stall_drop", 32'(cpu_stall), 0);
        chk("ar_busy_drop",  32'(seq_busy),  0);
        tick(); rst_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("ar_no_retrigger", 32'(seq_busy), 0);
        host_rst = 1'b0;
        tick();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
